// File: rtl/cpu_pkg.sv
// cpu_pkg: shared condition codes, status-register bit indices and branch condition evaluation
package cpu_pkg;
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] sr);
    logic n, z, c, v;
    n = sr[SR_N];
    z = sr[SR_Z];
    c = sr[SR_C];
    v = sr[SR_V];
    case (cc)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return ~c & ~z;
      COND_LS: return c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/flag_stack.sv
// flag_stack: small LIFO of status words with overflow/underflow strobes
module flag_stack #(
  parameter int DEPTH = 2,
  parameter int W = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] cnt,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic full, do_push, do_pop;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push & ~pop & ~full;
  assign do_pop = pop & ~push & ~empty;
  assign ovf = push & ~pop & full;
  assign unf = pop & ~push & empty;
  assign dout = empty ? '0 : mem[AW'(cnt - 1'b1)];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (do_push) cnt <= cnt + 1'b1;
    else if (do_pop) cnt <= cnt - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[AW'(cnt)] <= din;
  end
endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: status register, branch condition evaluation and interrupt shadow stack
module cond_flag_unit
  import cpu_pkg::*;
#(
  parameter int SHADOW_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alu_fz,
  input  logic                              alu_fc,
  input  logic                              alu_fn,
  input  logic                              alu_fv,
  input  logic                              flag_we,
  input  logic                              br_valid,
  input  logic [3:0]                        br_cond,
  output logic                              br_ready,
  output logic                              br_resp_valid,
  output logic                              br_taken,
  input  logic                              irq_save,
  input  logic                              irq_restore,
  output logic [3:0]                        sr_out,
  output logic [$clog2(SHADOW_DEPTH+1)-1:0] shadow_cnt,
  output logic                              stk_err
);
  logic [3:0] alu_flags, eff, stk_top;
  logic stk_empty, ovf, unf, pop_ok, accept;
  assign alu_flags = {alu_fn, alu_fz, alu_fc, alu_fv};
  // same-cycle flag write is forwarded to branches and saves
  assign eff = flag_we ? alu_flags : sr_out;
  assign br_ready = ~rst & ~irq_restore;
  assign accept = br_valid & br_ready;
  assign pop_ok = irq_restore & ~irq_save & ~stk_empty;
  flag_stack #(.DEPTH(SHADOW_DEPTH), .W(4)) u_stack (
    .clk,
    .rst,
    .push(irq_save),
    .pop(irq_restore),
    .din(eff),
    .dout(stk_top),
    .cnt(shadow_cnt),
    .empty(stk_empty),
    .ovf,
    .unf
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_out <= '0;
      stk_err <= 1'b0;
      br_resp_valid <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      sr_out <= pop_ok ? stk_top : eff;
      stk_err <= stk_err | ovf | unf;
      br_resp_valid <= accept;
      if (accept) br_taken <= cond_eval(br_cond, eff);
    end
  end
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed-vector checks of flags, branch conditions and shadow stack
module tb_cond_flag_unit;
  logic clk = 1'b0;
  logic rst, alu_fz, alu_fc, alu_fn, alu_fv, flag_we, br_valid, irq_save, irq_restore;
  logic [3:0] br_cond;
  logic br_ready, br_resp_valid, br_taken, stk_err;
  logic [3:0] sr_out;
  logic [1:0] shadow_cnt;
  int n_vec = 0;
  int n_err = 0;

  cond_flag_unit #(.SHADOW_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .alu_fz(alu_fz), .alu_fc(alu_fc), .alu_fn(alu_fn), .alu_fv(alu_fv),
    .flag_we(flag_we), .br_valid(br_valid), .br_cond(br_cond), .br_ready(br_ready),
    .br_resp_valid(br_resp_valid), .br_taken(br_taken), .irq_save(irq_save),
    .irq_restore(irq_restore), .sr_out(sr_out), .shadow_cnt(shadow_cnt), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [3:0] f);
    {alu_fn, alu_fz, alu_fc, alu_fv} = f;
  endtask

  task automatic idle();
    flag_we = 0; br_valid = 0; br_cond = 0; irq_save = 0; irq_restore = 0;
    set_alu(4'b0000);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    set_alu(4'b1111); flag_we = 1; irq_save = 1; br_valid = 1; br_cond = 4'd14;
    tick();
    idle();
    n_vec++; if (sr_out !== 4'b1111 || shadow_cnt !== 2'd1 || br_resp_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset sr=%b cnt=%0d rv=%b want 1111 1 1", sr_out, shadow_cnt, br_resp_valid); end
    #2 rst = 1;
    #1;
    n_vec++; if (sr_out !== 4'b0000) begin n_err++; $display("FAIL reset_sr got %b want 0000", sr_out); end
    n_vec++; if (shadow_cnt !== 2'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", shadow_cnt); end
    n_vec++; if (stk_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", stk_err); end
    n_vec++; if (br_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", br_ready); end
    n_vec++; if (br_resp_valid !== 1'b0 || br_taken !== 1'b0) begin n_err++; $display("FAIL reset_resp got %b/%b want 0/0", br_resp_valid, br_taken); end
    tick();
    rst = 0;
    #1;
    n_vec++; if (br_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b want 1", br_ready); end
  endtask

  task automatic test_forward_eq();
    set_alu(4'b0100); flag_we = 1; br_valid = 1; br_cond = 4'd0;
    tick();
    idle();
    n_vec++; if (br_resp_valid !== 1'b1 || br_taken !== 1'b1) begin n_err++; $display("FAIL fwd_eq got %b/%b want 1/1", br_resp_valid, br_taken); end
    n_vec++; if (sr_out !== 4'b0100) begin n_err++; $display("FAIL fwd_sr got %b want 0100", sr_out); end
    tick();
    n_vec++; if (br_resp_valid !== 1'b0 || br_taken !== 1'b1) begin n_err++; $display("FAIL resp_drop got %b/%b want 0/1", br_resp_valid, br_taken); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [5] = '{4'd8, 4'd9, 4'd11, 4'd10, 4'd12};
    logic exp [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    set_alu(4'b1010); flag_we = 1;
    tick();
    flag_we = 0;
    n_vec++; if (sr_out !== 4'b1010) begin n_err++; $display("FAIL sub_sr got %b want 1010", sr_out); end
    for (int i = 0; i < 5; i++) begin
      br_valid = 1; br_cond = codes[i];
      tick();
      n_vec++; if (br_resp_valid !== 1'b1 || br_taken !== exp[i]) begin n_err++; $display("FAIL b2b cond=%0d got %b/%b want 1/%b", codes[i], br_resp_valid, br_taken, exp[i]); end
    end
    idle();
  endtask

  task automatic test_cond_sweep();
    logic [15:0] exp = 16'b0110_1010_0110_1001;
    set_alu(4'b0101); flag_we = 1;
    tick();
    flag_we = 0;
    for (int i = 0; i < 16; i++) begin
      br_valid = 1; br_cond = 4'(i);
      tick();
      n_vec++; if (br_resp_valid !== 1'b1 || br_taken !== exp[i]) begin n_err++; $display("FAIL sweep cond=%0d got %b/%b want 1/%b", i, br_resp_valid, br_taken, exp[i]); end
    end
    idle();
  endtask

  task automatic test_stack();
    set_alu(4'b1000); flag_we = 1; irq_save = 1;
    tick();
    set_alu(4'b0001);
    tick();
    n_vec++; if (shadow_cnt !== 2'd2 || sr_out !== 4'b0001 || stk_err !== 1'b0) begin n_err++; $display("FAIL push2 got cnt=%0d sr=%b err=%b want 2 0001 0", shadow_cnt, sr_out, stk_err); end
    flag_we = 0;
    tick();
    n_vec++; if (shadow_cnt !== 2'd2 || stk_err !== 1'b1) begin n_err++; $display("FAIL overflow got cnt=%0d err=%b want 2 1", shadow_cnt, stk_err); end
    irq_save = 0; irq_restore = 1;
    #1;
    n_vec++; if (br_ready !== 1'b0) begin n_err++; $display("FAIL restore_ready got %b want 0", br_ready); end
    tick();
    n_vec++; if (sr_out !== 4'b0001 || shadow_cnt !== 2'd1) begin n_err++; $display("FAIL pop1 got sr=%b cnt=%0d want 0001 1", sr_out, shadow_cnt); end
    tick();
    n_vec++; if (sr_out !== 4'b1000 || shadow_cnt !== 2'd0) begin n_err++; $display("FAIL pop2 got sr=%b cnt=%0d want 1000 0", sr_out, shadow_cnt); end
    tick();
    n_vec++; if (sr_out !== 4'b1000 || shadow_cnt !== 2'd0 || stk_err !== 1'b1) begin n_err++; $display("FAIL underflow got sr=%b cnt=%0d err=%b want 1000 0 1", sr_out, shadow_cnt, stk_err); end
    idle();
    tick();
    n_vec++; if (stk_err !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b want 1", stk_err); end
  endtask

  task automatic test_restore_stall();
    set_alu(4'b0100); flag_we = 1; irq_save = 1;
    tick();
    idle();
    irq_restore = 1; br_valid = 1; br_cond = 4'd0;
    #1;
    n_vec++; if (br_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready got %b want 0", br_ready); end
    tick();
    n_vec++; if (br_resp_valid !== 1'b0 || sr_out !== 4'b0100 || shadow_cnt !== 2'd0) begin n_err++; $display("FAIL stall got rv=%b sr=%b cnt=%0d want 0 0100 0", br_resp_valid, sr_out, shadow_cnt); end
    irq_restore = 0;
    #1;
    n_vec++; if (br_ready !== 1'b1) begin n_err++; $display("FAIL unstall_ready got %b want 1", br_ready); end
    tick();
    br_valid = 0;
    n_vec++; if (br_resp_valid !== 1'b1 || br_taken !== 1'b1) begin n_err++; $display("FAIL late_resp got %b/%b want 1/1", br_resp_valid, br_taken); end
    tick();
    n_vec++; if (br_resp_valid !== 1'b0) begin n_err++; $display("FAIL late_drop got %b want 0", br_resp_valid); end
  endtask

  task automatic test_save_restore_same();
    set_alu(4'b1001); flag_we = 1; irq_save = 1;
    tick();
    set_alu(4'b0010); irq_restore = 1;
    #1;
    n_vec++; if (br_ready !== 1'b0) begin n_err++; $display("FAIL both_ready got %b want 0", br_ready); end
    tick();
    n_vec++; if (sr_out !== 4'b0010 || shadow_cnt !== 2'd1 || stk_err !== 1'b0) begin n_err++; $display("FAIL both got sr=%b cnt=%0d err=%b want 0010 1 0", sr_out, shadow_cnt, stk_err); end
    idle();
    irq_restore = 1;
    tick();
    idle();
    n_vec++; if (sr_out !== 4'b1001 || shadow_cnt !== 2'd0 || stk_err !== 1'b0) begin n_err++; $display("FAIL both_pop got sr=%b cnt=%0d err=%b want 1001 0 0", sr_out, shadow_cnt, stk_err); end
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    rst = 0;
    test_reset();
    test_forward_eq();
    test_back_to_back();
    test_cond_sweep();
    test_stack();
    do_reset();
    n_vec++; if (stk_err !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", stk_err); end
    test_restore_stall();
    test_save_restore_same();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer end of the ALU flag interface. Latches the ALU's Z/C/N/V outputs into the architectural status register (SR).
- Evaluates 4-bit branch condition codes against SR under a valid/ready request with a registered response.
- Holds a small LIFO shadow stack so SR can be saved on interrupt entry and restored on return.
- Sits between the ALU and the control unit / PC-select logic of the 16-bit CPU.

Parameters:
- SHADOW_DEPTH, 2, number of SR entries the interrupt shadow stack can hold (>=1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- alu_fz  in  1  ALU zero flag.
- alu_fc  in  1  ALU carry flag (borrow after SUB).
- alu_fn  in  1  ALU negative flag.
- alu_fv  in  1  ALU overflow flag.
- flag_we  in  1  latch the ALU flags into SR at this edge.
- br_valid  in  1  branch-condition request.
- br_cond  in  4  condition code for the request.
- br_ready  out  1  request can be accepted this cycle.
- br_resp_valid  out  1  one-cycle pulse; br_taken is valid.
- br_taken  out  1  condition result.
- irq_save  in  1  push SR onto the shadow stack.
- irq_restore  in  1  pop the top of the shadow stack into SR.
- sr_out  out  4  {N,Z,C,V}.
- shadow_cnt  out  $clog2(SHADOW_DEPTH+1)  occupied stack entries.
- stk_err  out  1  sticky: overflow or underflow occurred.

Behaviour:
- Reset (async, immediate):
  - sr_out=4'b0000, shadow_cnt=0, stk_err=0, br_resp_valid=0, br_taken=0.
  - br_ready=0 while rst is high.
- br_ready is combinational: ~rst & ~irq_restore. A restore cycle stalls requests for exactly that cycle.
- Effective flags for the cycle (eff):
  - If flag_we=1, eff = incoming ALU flags. This forwards the producing instruction into a same-cycle branch.
  - Otherwise eff = SR.
- Accept: at a rising edge with br_valid & br_ready:
  - br_taken <= cond(br_cond, eff).
  - br_resp_valid <= 1 for exactly one cycle, so latency is 1 cycle.
  - Back-to-back accepts give back-to-back responses.
  - With no accept, br_resp_valid <= 0 and br_taken holds.
- Condition codes:
  - 0 EQ Z; 1 NE ~Z
  - 2 CS C; 3 CC ~C
  - 4 MI N; 5 PL ~N
  - 6 VS V; 7 VC ~V
  - 8 HI ~C&~Z (unsigned a>b, C=borrow); 9 LS C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT ~Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 0
- SR update priority per edge:
  1. irq_restore (valid pop) loads the stack top.
  2. Else flag_we loads the ALU flags.
  3. Else SR holds.
- Save:
  - irq_save pushes eff (so a same-cycle flag_we value is saved) and shadow_cnt increments.
  - Push when shadow_cnt==SHADOW_DEPTH: stack unchanged, stk_err<=1.
- Restore:
  - irq_restore pops the top into SR and shadow_cnt decrements.
  - Pop when empty: SR takes the flag_we value or holds, stk_err<=1.
- irq_save & irq_restore in the same cycle:
  - Stack and SR restore are a no-op; no error.
  - flag_we still applies.
  - br_ready is still low that cycle.
- stk_err is cleared only by rst.
- Reset mid-operation: a pending response is dropped and stack contents are discarded (shadow_cnt=0).

Decomposition:
- Shared package (cpu_pkg):
  - Condition-code localparams COND_EQ..COND_NV.
  - SR bit indices SR_N=3, SR_Z=2, SR_C=1, SR_V=0.
- Sub-module flag_stack:
  - Parameterized LIFO of 4-bit entries.
  - push/pop/cnt/full/empty and overflow/underflow strobes.
- Condition evaluation is a function in the package, reused by the control unit.

Test Plan:
- Assert rst asynchronously mid-cycle -> same instant sr_out=0000, shadow_cnt=0, stk_err=0, br_ready=0, br_resp_valid=0.
- flag_we=1 with alu_fz=1, plus br_valid=1, br_cond=0 (EQ) same cycle -> next cycle br_resp_valid=1, br_taken=1, sr_out=0100.
- Latch SUB 3-5 flags (N=1,Z=0,C=1,V=0), then issue HI, LS, LT, GE, GT back-to-back -> br_taken 0,1,1,0,0 on consecutive cycles.
- SHADOW_DEPTH=2:
  - Save SR=1000, then save SR=0001, then a third save -> stk_err=1, shadow_cnt=2.
  - Restore -> sr_out=0001; restore -> sr_out=1000; third restore -> sr_out unchanged, shadow_cnt=0.
- br_valid held high with irq_restore=1 for one cycle -> br_ready=0, no response that cycle; accepted next cycle, response one cycle after that.
- irq_save=irq_restore=flag_we=1 with ALU flags 0010, shadow_cnt=1 -> sr_out=0010, shadow_cnt=1, stk_err=0.
